ct_fcnvt_htos_pipe: RTL and testbench

Two-stage pipelined IEEE-754 half-precision to single-precision converter in the vfalu conversion path. It is the widening counterpart of the single-to-half narrowing datapath: half denormals are renormalized by leading-zero count and left shift, not right-shifted into a subnormal field. Every half input is exactly representable in single, so the block does no rounding and the only exception it raises is NV on a signalling NaN.

---
 rtl/ct_fcnvt_htos_pipe.sv | 135 +++++++++++++
 tb/tb_ct_fcnvt_htos_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_fcnvt_htos_pipe.sv
// Two-stage fp16 -> fp32 widening converter: EX1 classifies and counts leading zeros, EX2 assembles the result.
// Optional build macro FCNVT_HTOS_CANON_NAN_EN: all NaN inputs produce the canonical qNaN.
module ct_fcnvt_htos_pipe (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        htos_flush,
    input  logic        htos_stall,
    input  logic        htos_in_vld,
    input  logic [15:0] htos_in_src,
    output logic        htos_out_vld,
    output logic [31:0] htos_out_result,
    output logic        htos_out_nv
);

    localparam int STAGES = 2;

    typedef enum logic [2:0] {
        C_ZERO   = 3'd0,
        C_DENORM = 3'd1,
        C_NORMAL = 3'd2,
        C_INF    = 3'd3,
        C_QNAN   = 3'd4,
        C_SNAN   = 3'd5
    } htos_cls_e;

    typedef struct packed {
        logic      sign;
        htos_cls_e cls;
        logic [4:0] exp;
        logic [9:0] mant;
        logic [3:0] lz;
    } ex1_t;

    logic [STAGES-1:0] vld_pipe;
    ex1_t              ex1, ex1_nxt;
    logic [4:0]        in_exp;
    logic [9:0]        in_mant;
    logic [3:0]        in_lz;
    htos_cls_e         in_cls;
    logic              load1, load2;
    logic [7:0]        exp_norm, exp_den;
    logic [9:0]        mant_den;
    logic [31:0]       res_nxt;
    logic              nv_nxt;

    assign in_exp  = htos_in_src[14:10];
    assign in_mant = htos_in_src[9:0];

    // Flush wins over stall and over a same-cycle input.
    assign load1 = htos_in_vld & ~htos_stall & ~htos_flush;
    assign load2 = vld_pipe[0] & ~htos_stall & ~htos_flush;

    always_comb begin
        in_cls = C_NORMAL;
        if (in_exp == 5'd0)
            in_cls = (in_mant == 10'd0) ? C_ZERO : C_DENORM;
        else if (in_exp == 5'd31) begin
            if (in_mant == 10'd0)
                in_cls = C_INF;
            else if (in_mant[9])
                in_cls = C_QNAN;
            else
                in_cls = C_SNAN;
        end
    end

    // Highest set bit wins; value for an all-zero mantissa is never used.
    always_comb begin
        in_lz = 4'd9;
        for (int i = 0; i < 10; i++)
            if (in_mant[i])
                in_lz = 4'(9 - i);
    end

    always_comb begin
        ex1_nxt      = '0;
        ex1_nxt.sign = htos_in_src[15];
        ex1_nxt.cls  = in_cls;
        ex1_nxt.exp  = in_exp;
        ex1_nxt.mant = in_mant;
        ex1_nxt.lz   = in_lz;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            vld_pipe <= '0;
        else if (htos_flush)
            vld_pipe <= '0;
        else if (!htos_stall)
            vld_pipe <= {vld_pipe[0], htos_in_vld};
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            ex1 <= '0;
        else if (load1)
            ex1 <= ex1_nxt;
    end

    // Denormals renormalize: shifting by lz+1 pushes the leading 1 out as the implicit bit.
    assign exp_norm = {3'b000, ex1.exp} + 8'd112;
    assign exp_den  = 8'd112 - {4'b0000, ex1.lz};
    assign mant_den = ex1.mant << (ex1.lz + 4'd1);

    always_comb begin
        res_nxt = 32'h0;
        nv_nxt  = (ex1.cls == C_SNAN);
        case (ex1.cls)
            C_ZERO:   res_nxt = {ex1.sign, 31'h0};
            C_NORMAL: res_nxt = {ex1.sign, exp_norm, ex1.mant, 13'h0};
            C_DENORM: res_nxt = {ex1.sign, exp_den, mant_den, 13'h0};
            C_INF:    res_nxt = {ex1.sign, 8'hFF, 23'h0};
            default: begin
`ifdef FCNVT_HTOS_CANON_NAN_EN
                res_nxt = 32'h7FC00000;
`else
                res_nxt = {ex1.sign, 8'hFF, 1'b1, ex1.mant[8:0], 13'h0};
`endif
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            htos_out_result <= 32'h0;
            htos_out_nv     <= 1'b0;
        end else if (load2) begin
            htos_out_result <= res_nxt;
            htos_out_nv     <= nv_nxt;
        end
    end

    assign htos_out_vld = vld_pipe[STAGES-1];

endmodule

// File: tb/tb_ct_fcnvt_htos_pipe.sv
// Scoreboard bench for ct_fcnvt_htos_pipe: directed vectors, stall, flush, async reset, random traffic.
module tb_ct_fcnvt_htos_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_vld = 1'b0;
    logic [15:0] src = 16'h0;
    logic        out_vld;
    logic [31:0] out_res;
    logic        out_nv;

    logic [32:0] exp_val = 33'h0;
    string       tg = "none";

    // Edge-time snapshot of the drive signals, taken with NBAs so values are pre-edge.
    logic        e_rst = 1'b0, e_flush = 1'b0, e_stall = 1'b0, e_vld = 1'b0;
    logic [32:0] e_exp = 33'h0;
    string       e_tg = "none";

    typedef struct {
        logic [32:0] v;
        int          k;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    int          checks = 0;
    int          failures = 0;
    int          adv_cnt = 0;
    logic        last_vld = 1'b0;
    logic [32:0] last_out = 33'h0;

    ct_fcnvt_htos_pipe dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .htos_flush     (flush),
        .htos_stall     (stall),
        .htos_in_vld    (in_vld),
        .htos_in_src    (src),
        .htos_out_vld   (out_vld),
        .htos_out_result(out_res),
        .htos_out_nv    (out_nv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, req);
        end
    endtask

    function automatic logic [32:0] model(input logic [15:0] h);
        logic        s;
        logic [4:0]  e;
        logic [9:0]  m;
        logic [10:0] mm;
        int          ee;
        s = h[15];
        e = h[14:10];
        m = h[9:0];
        if (e == 5'd31) begin
            if (m == 10'd0)
                return {1'b0, s, 8'hFF, 23'h0};
`ifdef FCNVT_HTOS_CANON_NAN_EN
            return {~m[9], 32'h7FC00000};
`else
            return {~m[9], s, 8'hFF, 1'b1, m[8:0], 13'h0};
`endif
        end
        if (e == 5'd0 && m == 10'd0)
            return {1'b0, s, 31'h0};
        if (e != 5'd0)
            return {1'b0, s, 8'(int'(e) + 112), m, 13'h0};
        // Value-level normalization: treat as exponent 1 with hidden 0, shift until the leading 1 is in place.
        ee = 113;
        mm = {1'b0, m};
        while (!mm[10]) begin
            mm = mm << 1;
            ee--;
        end
        return {1'b0, s, 8'(ee), mm[9:0], 13'h0};
    endfunction

    always @(posedge clk) begin
        e_rst   <= rst_n;
        e_flush <= flush;
        e_stall <= stall;
        e_vld   <= in_vld;
        e_exp   <= exp_val;
        e_tg    <= tg;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                chk("rst_vld", 64'(out_vld), 64'd0);
            end else if (!e_rst) begin
                chk("post_rst_vld", 64'(out_vld), 64'd0);
            end else if (e_flush) begin
                sb_q.delete();
                chk("flush_vld", 64'(out_vld), 64'd0);
            end else if (e_stall) begin
                chk("stall_vld", 64'(out_vld), 64'(last_vld));
                if (last_vld)
                    chk("stall_hold", 64'({out_nv, out_res}), 64'(last_out));
            end else begin
                adv_cnt++;
                if (e_vld)
                    sb_q.push_back('{e_exp, adv_cnt, e_tg});
                if (sb_q.size() > 0 && sb_q[0].k + 1 <= adv_cnt) begin
                    chk({sb_q[0].tag, "_vld"}, 64'(out_vld), 64'd1);
                    if (out_vld)
                        chk(sb_q[0].tag, 64'({out_nv, out_res}), 64'(sb_q[0].v));
                    void'(sb_q.pop_front());
                end else begin
                    chk("idle_vld", 64'(out_vld), 64'd0);
                end
            end
            last_vld = out_vld;
            last_out = {out_nv, out_res};
        end
    end

    task automatic drive(input logic [15:0] h, input logic [32:0] v, input string tag);
        @(posedge clk);
        #1;
        in_vld  = 1'b1;
        src     = h;
        exp_val = v;
        tg      = tag;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_vld = 1'b0;
        end
    endtask

    initial begin
        #1;
        chk("reset_vld", 64'(out_vld), 64'd0);
        chk("reset_res", 64'(out_res), 64'd0);
        chk("reset_nv", 64'(out_nv), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        drive(16'h3C00, {1'b0, 32'h3F800000}, "one");
        drive(16'hC000, {1'b0, 32'hC0000000}, "neg_two");
        drive(16'h7BFF, {1'b0, 32'h477FE000}, "max_norm");
        drive(16'hFC00, {1'b0, 32'hFF800000}, "neg_inf");
        drive(16'h0001, {1'b0, 32'h33800000}, "min_den");
        drive(16'h03FF, {1'b0, 32'h387FC000}, "max_den");
        drive(16'h8200, {1'b0, 32'hB8000000}, "neg_den");
        drive(16'h8000, {1'b0, 32'h80000000}, "neg_zero");
`ifdef FCNVT_HTOS_CANON_NAN_EN
        drive(16'h7C01, {1'b1, 32'h7FC00000}, "snan");
        drive(16'hFE00, {1'b0, 32'h7FC00000}, "qnan");
`else
        drive(16'h7C01, {1'b1, 32'h7FC02000}, "snan");
        drive(16'hFE00, {1'b0, 32'hFFC00000}, "qnan");
`endif
        idle(3);

        // Stall with A in EX2 and B in EX1.
        drive(16'h3C00, {1'b0, 32'h3F800000}, "stall_a");
        drive(16'h4000, {1'b0, 32'h40000000}, "stall_b");
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        stall  = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        idle(3);

        // Flush with one op in EX1 and a same-cycle input.
        drive(16'h3800, {1'b0, 32'h3F000000}, "flushed_x");
        @(posedge clk);
        #1;
        in_vld  = 1'b1;
        src     = 16'hBC00;
        exp_val = {1'b0, 32'hBF800000};
        tg      = "flushed_y";
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush  = 1'b0;
        in_vld = 1'b0;
        idle(1);
        drive(16'h4400, {1'b0, 32'h40800000}, "after_flush");
        idle(3);

        // Async reset with both stages valid.
        drive(16'h3C00, {1'b0, 32'h3F800000}, "rst_a");
        drive(16'h4000, {1'b0, 32'h40000000}, "rst_b");
        @(posedge clk);
        #1 in_vld = 1'b0;
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("async_rst_vld", 64'(out_vld), 64'd0);
        chk("async_rst_res", 64'(out_res), 64'd0);
        chk("async_rst_nv", 64'(out_nv), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(3);
        drive(16'h4200, {1'b0, 32'h40400000}, "after_rst");
        idle(3);

        // Random traffic with random stalls; special exponents are weighted up.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] h;
            h = 16'($urandom);
            case ($urandom_range(0, 3))
                0: h[14:10] = 5'd0;
                1: h[14:10] = 5'd31;
                default: ;
            endcase
            @(posedge clk);
            #1;
            in_vld  = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            src     = h;
            exp_val = model(h);
            tg      = "rand";
        end
        @(posedge clk);
        #1;
        stall  = 1'b0;
        in_vld = 1'b0;
        idle(4);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
